// File: rtl/fifo_sram_ctrl.sv
// FIFO controller for a single-clock simple dual-port SRAM with combinational read.
// Owns pointers, occupancy, runtime-configurable active depth and level flags.
module fifo_sram_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [DATA_SIZE-1:0] push_data,
    output logic                 pop_valid,
    input  logic                 pop_ready,
    output logic [DATA_SIZE-1:0] pop_data,
    input  logic [ADDR_SIZE:0]   cfg_depth,
    input  logic                 cfg_load,
    input  logic [ADDR_SIZE:0]   af_level,
    input  logic [ADDR_SIZE:0]   ae_level,
    output logic [ADDR_SIZE:0]   count,
    output logic [ADDR_SIZE:0]   depth,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 cfg_err,
    output logic                 mem_write_enable,
    output logic [ADDR_SIZE-1:0] mem_write_address,
    output logic [DATA_SIZE-1:0] mem_write_data,
    output logic                 mem_read_enable,
    output logic [ADDR_SIZE-1:0] mem_read_address,
    input  logic [DATA_SIZE-1:0] mem_read_data
);
    localparam int CW = ADDR_SIZE + 1;
    localparam logic [CW-1:0] MAXD = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [CW-1:0] ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE-1:0] PTR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        depth_q, depth_d;
    logic                 cfg_err_q, cfg_err_d;

    logic          push_fire, pop_fire;
    logic          wr_last, rd_last, cfg_accept;
    logic [CW-1:0] cfg_clamped;

    // Handshake: a word moves on any edge where valid && ready are both high.
    assign push_ready = !rst && !cfg_load && (count_q < depth_q);
    assign pop_valid  = !rst && (count_q != '0);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_valid && pop_ready;

    assign pop_data          = mem_read_data;
    assign mem_write_enable  = push_fire;
    assign mem_write_address = wr_ptr_q;
    assign mem_write_data    = push_data;
    assign mem_read_enable   = pop_valid;
    assign mem_read_address  = rd_ptr_q;

    assign count        = count_q;
    assign depth        = depth_q;
    assign cfg_err      = cfg_err_q;
    assign almost_full  = (count_q >= af_level);
    assign almost_empty = (count_q <= ae_level);

    // Pointers wrap at the active depth so non-power-of-two depths work.
    assign wr_last     = ({1'b0, wr_ptr_q} == (depth_q - ONE));
    assign rd_last     = ({1'b0, rd_ptr_q} == (depth_q - ONE));
    assign cfg_accept  = cfg_load && (count_q == '0);
    assign cfg_clamped = ((cfg_depth == '0) || (cfg_depth > MAXD)) ? MAXD : cfg_depth;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        depth_d   = depth_q;
        cfg_err_d = cfg_err_q;

        if (cfg_accept) begin
            depth_d  = cfg_clamped;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (cfg_load) begin
                cfg_err_d = 1'b1;
            end
            if (push_fire) begin
                wr_ptr_d = wr_last ? '0 : wr_ptr_q + PTR_ONE;
            end
            if (pop_fire) begin
                rd_ptr_d = rd_last ? '0 : rd_ptr_q + PTR_ONE;
            end
        end

        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            depth_q   <= MAXD;
            cfg_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            depth_q   <= depth_d;
            cfg_err_q <= cfg_err_d;
        end
    end
endmodule

// File: tb/tb_fifo_sram_ctrl.sv
// Bench for fifo_sram_ctrl: table of cycle vectors plus directed sequences,
// with an SRAM array and an expected-data queue monitored every cycle.
module tb_fifo_sram_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       push_valid, push_ready, pop_valid, pop_ready, cfg_load;
    logic [7:0] push_data, pop_data, mem_write_data, mem_read_data;
    logic [4:0] cfg_depth, af_level, ae_level, count, depth;
    logic       almost_full, almost_empty, cfg_err;
    logic       mem_write_enable, mem_read_enable;
    logic [3:0] mem_write_address, mem_read_address;

    int checks = 0;
    int errors = 0;
    int exp_depth = 16;
    bit sb_on = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] mem[16];

    typedef struct {
        logic       pv;
        logic [7:0] pd;
        logic       pr;
        int         cnt;
        logic       prdy;
        logic       pval;
        logic [7:0] data;
    } vec_t;
    vec_t tbl[8];

    fifo_sram_ctrl #(.ADDR_SIZE(4), .DATA_SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .cfg_depth(cfg_depth), .cfg_load(cfg_load),
        .af_level(af_level), .ae_level(ae_level),
        .count(count), .depth(depth),
        .almost_full(almost_full), .almost_empty(almost_empty), .cfg_err(cfg_err),
        .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data),
        .mem_read_enable(mem_read_enable), .mem_read_address(mem_read_address),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_write_address] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_read_address];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: occupancy, ready, write strobe and pop ordering every cycle.
    always @(negedge clk) begin
        if (sb_on && !rst) begin
            logic exp_rdy;
            exp_rdy = (exp_q.size() < exp_depth) && !cfg_load;
            chk("sb_count", 32'(count), 32'(exp_q.size()));
            chk("sb_push_ready", 32'(push_ready), 32'(exp_rdy));
            chk("sb_pop_valid", 32'(pop_valid), 32'(exp_q.size() != 0));
            chk("sb_wr_en", 32'(mem_write_enable), 32'(push_valid && exp_rdy));
            if (pop_valid && pop_ready && exp_q.size() != 0) begin
                chk("sb_pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
            end
            if (push_valid && exp_rdy) exp_q.push_back(push_data);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (count == 0) done = 1'b1;
            else next_cycle();
        end
        chk({nm, "_drained"}, 32'(done), 32'd1);
        chk({nm, "_pop_valid_empty"}, 32'(pop_valid), 32'd0);
        pop_ready = 1'b0;
        next_cycle();
    endtask

    initial begin
        int acc;
        int pushed;
        int wr_idx;

        rst = 1'b1; push_valid = 1'b0; push_data = 8'h00; pop_ready = 1'b0;
        cfg_load = 1'b0; cfg_depth = 5'd0; af_level = 5'd15; ae_level = 5'd0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_depth", 32'(depth), 32'd16);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_push_ready", 32'(push_ready), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        sb_on = 1'b1;

        // Basic in-order push then pop; outputs are those seen before each edge.
        tbl[0] = '{1'b1, 8'h11, 1'b0, 0, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1, 1'b1, 1'b1, 8'h11};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 2, 1'b1, 1'b1, 8'h11};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 3, 1'b1, 1'b1, 8'h11};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 3, 1'b1, 1'b1, 8'h11};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 8'h22};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 8'h33};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'h00};
        for (int v = 0; v < 8; v++) begin
            push_valid = tbl[v].pv; push_data = tbl[v].pd; pop_ready = tbl[v].pr;
            @(negedge clk);
            chk($sformatf("tbl%0d_count", v), 32'(count), 32'(tbl[v].cnt));
            chk($sformatf("tbl%0d_push_ready", v), 32'(push_ready), 32'(tbl[v].prdy));
            chk($sformatf("tbl%0d_pop_valid", v), 32'(pop_valid), 32'(tbl[v].pval));
            if (tbl[v].pval) chk($sformatf("tbl%0d_pop_data", v), 32'(pop_data), 32'(tbl[v].data));
            next_cycle();
        end

        // Fill to the default depth of 16 and hold push_valid while full.
        acc = 0;
        push_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_data = 8'h40 + 8'(i);
            @(negedge clk);
            if (push_valid && push_ready) acc++;
            next_cycle();
        end
        @(negedge clk);
        chk("full_accepted", 32'(acc), 32'd16);
        chk("full_count", 32'(count), 32'd16);
        chk("full_push_ready", 32'(push_ready), 32'd0);
        chk("full_no_write", 32'(mem_write_enable), 32'd0);
        next_cycle();
        drain("full");

        // Depth 5: pointers must wrap 4 -> 0 while streaming 12 words.
        cfg_depth = 5'd5; cfg_load = 1'b1;
        next_cycle();
        cfg_load = 1'b0;
        exp_depth = 5;
        chk("cfg5_depth", 32'(depth), 32'd5);
        pushed = 0; wr_idx = 0;
        for (int c = 0; c < 60 && (pushed < 12 || count != 0); c++) begin
            push_valid = (pushed < 12);
            push_data  = 8'h80 + 8'(pushed);
            pop_ready  = (pushed >= 3);
            @(negedge clk);
            chk("cfg5_count_le5", 32'(count <= 5), 32'd1);
            if (push_valid && push_ready) begin
                chk("cfg5_wr_addr", 32'(mem_write_address), 32'(wr_idx % 5));
                wr_idx++;
                pushed++;
            end
            next_cycle();
        end
        chk("cfg5_pushed", 32'(pushed), 32'd12);
        drain("cfg5");

        // Simultaneous push and pop holds count at 2.
        push_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_data = 8'hA0 + 8'(i);
            next_cycle();
        end
        pop_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_data = 8'hA2 + 8'(i);
            @(negedge clk);
            chk("both_count", 32'(count), 32'd2);
            next_cycle();
        end
        drain("both");

        // Rejected load while non-empty, then a clamped load when empty.
        push_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_data = 8'hC0 + 8'(i);
            next_cycle();
        end
        push_valid = 1'b0;
        cfg_depth = 5'd8; cfg_load = 1'b1;
        next_cycle();
        cfg_load = 1'b0;
        @(negedge clk);
        chk("rej_depth", 32'(depth), 32'd5);
        chk("rej_cfg_err", 32'(cfg_err), 32'd1);
        chk("rej_count", 32'(count), 32'd3);
        next_cycle();
        drain("rej");
        cfg_depth = 5'd0; cfg_load = 1'b1;
        next_cycle();
        cfg_load = 1'b0;
        exp_depth = 16;
        chk("clamp_depth", 32'(depth), 32'd16);
        chk("clamp_cfg_err_sticky", 32'(cfg_err), 32'd1);

        // Level flags with af=4, ae=1, then reset mid-stream.
        af_level = 5'd4; ae_level = 5'd1;
        for (int k = 0; k <= 4; k++) begin
            push_valid = (k < 4);
            push_data  = 8'hE0 + 8'(k);
            @(negedge clk);
            chk($sformatf("flag%0d_af", k), 32'(almost_full), 32'(k >= 4));
            chk($sformatf("flag%0d_ae", k), 32'(almost_empty), 32'(k <= 1));
            next_cycle();
        end
        push_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_pop_valid", 32'(pop_valid), 32'd0);
        chk("midrst_push_ready", 32'(push_ready), 32'd0);
        chk("midrst_depth", 32'(depth), 32'd16);
        chk("midrst_cfg_err", 32'(cfg_err), 32'd0);
        exp_q.delete();
        exp_depth = 16;
        push_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("post_rst_push_ready", 32'(push_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_sram_ctrl.md
Name: fifo_sram_ctrl

Overview:
Synchronous FIFO controller placed directly upstream of the single-clock simple dual-port SRAM. It owns the read and write pointers, occupancy and flags, and drives the SRAM write port, read port and data path. It exposes valid/ready push and pop interfaces. The active depth is configurable at runtime, up to the SRAM capacity.

Parameters:
ADDR_SIZE, 4, SRAM address width; maximum depth MAXD = 2^ADDR_SIZE
DATA_SIZE, 8, data word width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
push_valid  input  1  producer has a word
push_ready  output  1  controller can accept a word
push_data  input  DATA_SIZE  word to write
pop_valid  output  1  head word available on pop_data
pop_ready  input  1  consumer takes the head word
pop_data  output  DATA_SIZE  head word (driven from mem_read_data)
cfg_depth  input  ADDR_SIZE+1  requested active depth
cfg_load  input  1  apply cfg_depth (honoured only when empty)
af_level  input  ADDR_SIZE+1  almost-full threshold
ae_level  input  ADDR_SIZE+1  almost-empty threshold
count  output  ADDR_SIZE+1  current occupancy
depth  output  ADDR_SIZE+1  active depth
almost_full  output  1  count >= af_level
almost_empty  output  1  count <= ae_level
cfg_err  output  1  sticky: cfg_load rejected
mem_write_enable  output  1  SRAM write strobe
mem_write_address  output  ADDR_SIZE  SRAM write address
mem_write_data  output  DATA_SIZE  SRAM write data
mem_read_enable  output  1  SRAM read strobe
mem_read_address  output  ADDR_SIZE  SRAM read address
mem_read_data  input  DATA_SIZE  SRAM read data (combinational read of read_address)

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = 0, rd_ptr = 0, count = 0, depth = MAXD, cfg_err = 0.
  - push_ready = 0 and pop_valid = 0 while rst is high.
- Push handshake:
  - push_ready = !rst && !cfg_load && (count < depth).
  - push_fire = push_valid && push_ready.
- Pop handshake:
  - pop_valid = (count != 0).
  - pop_fire = pop_valid && pop_ready.
  - pop_data = mem_read_data, valid in the same cycle, because the SRAM read is combinational.
- SRAM drive:
  - mem_write_enable = push_fire; mem_write_address = wr_ptr; mem_write_data = push_data.
  - mem_read_enable = pop_valid; mem_read_address = rd_ptr.
- Pointers:
  - Advance by 1 on their fire.
  - Wrap to 0 after depth-1, not after MAXD, so non-power-of-two depths work.
- Count update:
  - +1 on push_fire only.
  - -1 on pop_fire only.
  - Unchanged when both fire or neither fires.
- Full (count == depth):
  - push_ready = 0. No same-cycle push/pop bypass.
  - A pop in that cycle frees a slot from the next cycle onward.
- Empty (count == 0):
  - pop_valid = 0. No write-to-read fall-through.
  - A word pushed at edge N is visible on pop_data after edge N.
- Simultaneous push and pop at 0 < count < depth:
  - Both accepted; count unchanged.
  - Read and write addresses differ, so there is no SRAM collision.
- Configuration load:
  - On the edge where cfg_load = 1 and count == 0: depth is set from cfg_depth, and wr_ptr and rd_ptr reset to 0.
  - cfg_depth = 0 or > MAXD is clamped to MAXD.
  - cfg_load with count != 0: ignored, and cfg_err is set to 1.
  - cfg_err clears only on reset.
  - A push is blocked in any cycle where cfg_load = 1.
- Flags:
  - Combinational from the registered count and the level inputs.
  - depth output = the depth register.
- Reset mid-operation: all state returns to the reset values immediately; stored SRAM contents are abandoned.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 with pop_ready = 0 -> count = 3, pop_valid = 1, pop_data = 0x11; then pop_ready = 1 for 3 cycles -> 0x11, 0x22, 0x33 in order, count = 0, pop_valid = 0.
- Default depth 16: push continuously -> push_ready drops after 16 accepted words, count = 16. A push_valid held while full is not written (mem_write_enable = 0).
- cfg_depth = 5 with cfg_load while empty -> depth = 5. Push 12 words while popping after the first 3 -> pointers wrap 4 -> 0, data order preserved, count never exceeds 5.
- At count = 2, push_valid and pop_ready high together for 10 cycles -> count stays 2 and output data is in order.
- At count = 3, pulse cfg_load with cfg_depth = 8 -> depth unchanged, cfg_err = 1. cfg_load with cfg_depth = 0 when empty -> depth = 16.
- af_level = 4, ae_level = 1: push 4 words -> almost_full rises exactly at count = 4, almost_empty falls at count = 2. Assert rst mid-stream -> count = 0, pop_valid = 0, push_ready = 0 immediately.
